// File: rtl/sn76489_bus_writer.sv
// SN76489 register-write bus master: encodes (register, value) commands into
// latch/data byte strobes on the chip bus, with READY handshake and timeout.
module sn76489_bus_writer #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_MIN  = 2,
  parameter int RDY_TIMEOUT = 256,
  parameter int GAP_CYC     = 2
) (
  input  logic       clock_i,
  input  logic       res_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_reg_i,
  input  logic [9:0] cmd_val_i,
  output logic       done_o,
  output logic       err_o,
  input  logic       err_clr_i,
  output logic       busy_o,
  output logic [7:0] d_o,
  output logic       ce_n_o,
  output logic       we_n_o,
  input  logic       ready_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  localparam int MAX_SG  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int MAX_ST  = (STROBE_MIN > RDY_TIMEOUT) ? STROBE_MIN : RDY_TIMEOUT;
  localparam int CNT_MAX = (MAX_SG > MAX_ST) ? MAX_SG : MAX_ST;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] CNT_SMIN  = CNT_W'(STROBE_MIN);
  localparam logic [CNT_W-1:0] CNT_TMO   = CNT_W'(RDY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GAP_CYC);

  // Returns {two_byte, data_byte, latch_byte}; noise control keeps only v[2:0].
  function automatic logic [16:0] encode_cmd(input logic [2:0] r, input logic [9:0] v);
    logic [3:0] nib;
    logic       two;
    if (r == 3'd6) begin
      nib = {1'b0, v[2:0]};
    end else begin
      nib = v[3:0];
    end
    two = (r[0] == 1'b0) && (r[2:1] != 2'b11);
    return {two, 2'b00, v[9:4], 1'b1, r, nib};
  endfunction

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       data_r;
  logic             pend_r;
  logic [7:0]       d_r;
  logic             ce_n_r;
  logic             we_n_r;
  logic             done_r;
  logic             err_r;
  logic [16:0]      enc_s;
  logic             strobe_ok_s;
  logic             timeout_s;

  assign enc_s       = encode_cmd(cmd_reg_i, cmd_val_i);
  assign cmd_ready_o = (state_r == ST_IDLE) && !res_i;
  assign busy_o      = (state_r != ST_IDLE);
  assign d_o         = d_r;
  assign ce_n_o      = ce_n_r;
  assign we_n_o      = we_n_r;
  assign done_o      = done_r;
  assign err_o       = err_r;

  // Strobe exit decode: handshake completion, else READY timeout
  always_comb begin
    strobe_ok_s = 1'b0;
    timeout_s   = 1'b0;
    if (state_r == ST_STROBE) begin
      strobe_ok_s = (cnt_r >= CNT_SMIN) && ready_i;
      timeout_s   = !strobe_ok_s && (cnt_r >= CNT_TMO);
    end else begin
      strobe_ok_s = 1'b0;
      timeout_s   = 1'b0;
    end
  end

  // Bus sequencer: IDLE -> SETUP -> STROBE -> GAP, repeating once for a data byte
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      data_r  <= 8'h00;
      pend_r  <= 1'b0;
      d_r     <= 8'h00;
      ce_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            state_r <= ST_SETUP;
            cnt_r   <= CNT_ONE;
            d_r     <= enc_s[7:0];
            data_r  <= enc_s[15:8];
            pend_r  <= enc_s[16];
          end
        end
        ST_SETUP: begin
          if (cnt_r >= CNT_SETUP) begin
            state_r <= ST_STROBE;
            cnt_r   <= CNT_ONE;
            ce_n_r  <= 1'b0;
            we_n_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STROBE: begin
          if (strobe_ok_s || timeout_s) begin
            state_r <= ST_GAP;
            cnt_r   <= CNT_ONE;
            ce_n_r  <= 1'b1;
            we_n_r  <= 1'b1;
            if (timeout_s) begin
              pend_r <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_r >= CNT_GAP) begin
            if (pend_r) begin
              state_r <= ST_SETUP;
              cnt_r   <= CNT_ONE;
              d_r     <= data_r;
              pend_r  <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              cnt_r   <= CNT_ZERO;
              done_r  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          pend_r  <= 1'b0;
          ce_n_r  <= 1'b1;
          we_n_r  <= 1'b1;
        end
      endcase
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as a clear keeps it set
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end else if (err_clr_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: doc/sn76489_bus_writer.md
# sn76489_bus_writer

Bus master for the SN76489 register write port. It accepts abstract register-write commands (register index 0–7, value) and encodes them into the chip's latch/data byte sequence. It drives `d_o`, `ce_n_o` and `we_n_o` under the `ready` handshake, and reports completion and timeouts. It sits between a sequencer or host and `sn76489_top`, and the stimulus layer reuses it as a bus-functional driver.

## Interface
Parameters:
- SETUP_CYC, 1: cycles `d_o` is stable before strobe assertion (≥1)
- STROBE_MIN, 2: minimum cycles `ce_n_o`/`we_n_o` are held low (≥1)
- RDY_TIMEOUT, 256: maximum strobe cycles waiting for ready high (≥STROBE_MIN)
- GAP_CYC, 2: cycles strobes stay high between bytes and after the last byte (≥1)

Ports:
- clock_i  in  1  system clock; all logic on the rising edge
- res_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  writer can accept a command
- cmd_reg_i  in  3  register index: bits[2:1] = channel (3 = noise), bit0 = 1 for attenuation
- cmd_val_i  in  10  register value
- done_o  out  1  one-cycle pulse when a command finishes
- err_o  out  1  sticky timeout flag
- err_clr_i  in  1  clears err_o
- busy_o  out  1  command in progress
- d_o  out  8  chip data bus; bit7 = latch flag
- ce_n_o  out  1  chip enable, active low
- we_n_o  out  1  write enable, active low
- ready_i  in  1  chip READY; high = idle/accepting

## Operation
- Accept on cmd_valid_i && cmd_ready_o. cmd_reg_i and cmd_val_i are captured into holding registers, so inputs may change afterwards.
- Byte encoding:
  - Latch byte = {1, ch[1:0], bit0, v[3:0]}.
  - Tone frequency registers (0, 2, 4) also send a data byte = {0, 0, v[9:4]}, so two bytes total.
  - Attenuation registers (1, 3, 5, 7): one byte; only v[3:0] is used, v[9:4] is ignored.
  - Noise control (6): one byte; latch low nibble = {0, v[2:0]}, v[9:3] is ignored.
- FSM states are IDLE, SETUP, STROBE, GAP.
  - IDLE → SETUP on accept. d_o is loaded with the latch byte.
  - SETUP holds SETUP_CYC cycles with strobes high → STROBE.
  - STROBE drives ce_n_o = we_n_o = 0. The strobe counter counts from 1. Exit → GAP when count ≥ STROBE_MIN and ready_i == 1.
  - Timeout: if count reaches RDY_TIMEOUT without exit → GAP, err_o set, and any remaining data byte is dropped.
  - GAP holds GAP_CYC cycles with strobes high and d_o held. Then → SETUP with d_o = data byte if one is pending; otherwise → IDLE with done_o pulsed.
- done_o pulses for timed-out commands too. err_o distinguishes them.
- cmd_ready_o = (state == IDLE) && !res_i. busy_o = !(state == IDLE).
- err_o: set on timeout, cleared by err_clr_i or res_i. A set on the same cycle as err_clr_i wins.
- Reset (any state, including mid-strobe): state IDLE, ce_n_o = we_n_o = 1, d_o = 0x00, done_o = 0, err_o = 0, busy_o = 0, counters 0, pending byte discarded. cmd_ready_o = 0 during reset, 1 on the first cycle after it.

## Timing
- All outputs are registered except cmd_ready_o and busy_o, which decode from the state register.
- Accept at edge T: d_o is valid at T+1. Strobes fall at T+1+SETUP_CYC.
- A single-byte command with ready_i already high occupies SETUP_CYC + STROBE_MIN + GAP_CYC cycles from accept to done_o. The next accept is possible on the done_o cycle.
- A two-byte command takes 2 × (SETUP_CYC + strobe length + GAP_CYC) cycles.
- ready_i is sampled only in STROBE. A low-then-high glitch before STROBE_MIN is ignored.
- cmd_valid_i while busy is not accepted and must be held by the source.

## Test plan
- Register 0, value 0x1FE, ready_i tied high, defaults:
  - d_o = 0x8E, strobe low 2 cycles; then d_o = 0x1F, strobe low 2 cycles.
  - done_o exactly 10 cycles after accept.
  - Chip tone1 f_q reads 0x1FE.
- Registers 1 (0xF), 6 (0x3FD), 7 (0x3): bytes 0x9F, 0xE5, 0xF3, each a single strobe. Chip a_q/noise registers match.
- ready_i pulled low 1 cycle into STROBE and released after 40 cycles: strobe stays low for 40+ cycles, leaves on the first cycle ready_i is high, err_o stays 0.
- ready_i stuck low, register 2 command: strobe low exactly 256 cycles, err_o = 1, data byte never driven, done_o pulses. err_clr_i clears err_o.
- res_i asserted mid-STROBE of the data byte: next cycle ce_n_o = we_n_o = 1, d_o = 0x00, busy_o = 0, cmd_ready_o = 1 after release. The next command encodes correctly.
- Back-to-back registers 0–7 with value i+1, cmd_valid_i held high: eight done_o pulses, eleven strobes in total. Chip registers: tone1 f = 1, a = 2; tone2 f = 3, a = 4; tone3 f = 5, a = 6; noise = 7, a = 8 → 0x8.
